adder_seq_ctrl: RTL and testbench
=================================

# adder_seq_ctrl

Sequencing controller that shares one 4-bit add/subtract nibble stage between two requesters and runs multi-nibble (4·NIB-bit) add/subtract operations serially, least-significant nibble first, with a registered carry between nibbles. It sits between two operand producers and one result consumer. It provides round-robin arbitration, valid/ready handshakes on both sides, and a held result until the consumer accepts it. The nibble stage has the same function as adder4bit (B inverted when P=1), except carry-in is an explicit input, so nibbles above 0 take the registered carry.

## Interface
- NIB, default 4: number of nibbles per operand. W = 4·NIB is the operand width. Legal NIB ≥ 1.

- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- REQ0_VALID  input  1  requester 0 holds an operation
- REQ0_READY  output  1  requester 0 operation accepted this cycle
- REQ0_A  input  W  requester 0 operand A
- REQ0_B  input  W  requester 0 operand B
- REQ0_P  input  1  requester 0 mode: 0 = A+B, 1 = A−B
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_P: same as requester 0, for requester 1
- RES_VALID  output  1  result available
- RES_READY  input  1  consumer accepts result
- RES_S  output  W  sum/difference, modulo 2^W
- RES_CO  output  1  final carry out; for subtraction 1 = no borrow (A ≥ B unsigned)
- RES_ID  output  1  requester that issued the result
- BUSY  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - If any REQx_VALID is high, the grant goes to the requester selected by the round-robin pointer PTR when both are valid, otherwise to the sole valid requester.
  - REQx_READY for the winner is driven high combinationally in the same cycle. The loser's READY is 0.
  - At that clock edge, the controller latches A, B, P and ID, sets the carry register C = P and the nibble index k = 0, and moves to RUN.
- RUN
  - Each cycle, nibble k computes A[k] + (B[k] ^ {4{P}}) + C. The result is written into RES_S[4k+3:4k] and C takes the nibble carry out. Then k increments.
  - After nibble NIB−1 is written, RES_CO = C and the state moves to DONE.
  - Both READY outputs are 0 throughout RUN.
- DONE
  - RES_VALID is high. RES_S, RES_CO and RES_ID are held stable.
  - On the first edge where RES_READY = 1: the state returns to IDLE, RES_VALID drops, and PTR is set to the requester not served (!RES_ID).
  - No new request is accepted in DONE.
- Requester rules
  - REQx_VALID must stay high until REQx_READY. Operands are sampled only on the handshake cycle, and later changes have no effect.
  - A requester that drops VALID before READY is simply not served.
- Reset: all state clears asynchronously.
  - state = IDLE, PTR = 0, k = 0, C = 0.
  - RES_S = 0, RES_CO = 0, RES_ID = 0, RES_VALID = 0, both READY = 0, BUSY = 0.
  - Reset during RUN or DONE discards the operation, and no result is ever presented for it.

## Timing
- Acceptance edge E0: the cycle in which REQx_VALID and REQx_READY are both high.
- RUN occupies NIB cycles after E0. RES_VALID rises after edge E0+NIB, i.e. NIB edges after acceptance.
- Minimum spacing between acceptances is NIB+2 cycles (IDLE, NIB×RUN, DONE with RES_READY already high).
- RES_VALID falls on the edge where RES_READY is sampled high in DONE. The next acceptance can occur one cycle later, in IDLE.
- RES_S is stable only while RES_VALID = 1. Nibbles update progressively during RUN.
- BUSY is high from the cycle after E0 until the cycle after the result handshake.

## Configuration
- ADDSEQ_OVF_EN
  - Defined: adds output RES_OVF (1 bit), the signed two's-complement overflow. It equals the carry into the MSB of nibble NIB−1 XOR RES_CO. It is registered with RES_CO, held in DONE, and reset to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan (NIB = 4)
- REQ0 A=0x1234, B=0x0FCD, P=0 → RES_S=0x2201, RES_CO=0, RES_ID=0. RES_VALID rises 4 edges after acceptance.
- REQ1 A=0x0005, B=0x0007, P=1 → RES_S=0xFFFE, RES_CO=0. Then A=0x0007, B=0x0005, P=1 → RES_S=0x0002, RES_CO=1.
- After reset, both VALID held high continuously with RES_READY=1 → RES_ID sequence 0, 1, 0, 1, with no grant while BUSY=1.
- Result handshake with RES_READY held low 5 cycles in DONE → RES_VALID, RES_S and RES_ID stable, both READY stay 0, and IDLE is entered only after RES_READY=1.
- Wrap-around: 0xFFFF + 0x0001, P=0 → RES_S=0x0000, RES_CO=1. With ADDSEQ_OVF_EN, 0x7FFF + 0x0001 → RES_S=0x8000, RES_CO=0, RES_OVF=1.
- RST pulsed during RUN nibble 2 → all outputs 0 immediately and no RES_VALID after release. A subsequent REQ0 0x0001+0x0001 → RES_S=0x0002, RES_ID=0.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Round-robin shared 4-bit add/sub nibble stage; ops run NIB cycles LSB-nibble first, result held until RES_READY.
// No request accepted outside IDLE; RES_OVF signed-overflow output exists only when ADDSEQ_OVF_EN is defined.
module adder_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    output logic             REQ0_READY,
    input  logic [4*NIB-1:0] REQ0_A,
    input  logic [4*NIB-1:0] REQ0_B,
    input  logic             REQ0_P,
    input  logic             REQ1_VALID,
    output logic             REQ1_READY,
    input  logic [4*NIB-1:0] REQ1_A,
    input  logic [4*NIB-1:0] REQ1_B,
    input  logic             REQ1_P,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [4*NIB-1:0] RES_S,
    output logic             RES_CO,
`ifdef ADDSEQ_OVF_EN
    output logic             RES_OVF,
`endif
    output logic             RES_ID,
    output logic             BUSY
);
    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ptr;
    logic [KW-1:0]   r_k;
    logic            r_c;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_p;
    logic            r_id;
    logic [W-1:0]    r_s;
    logic            r_co;
`ifdef ADDSEQ_OVF_EN
    logic            r_ovf;
`endif

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_last;
    logic [KW+1:0]   w_bit_idx;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [4:0]      w_sum;

    assign w_last    = (r_k == K_LAST);
    assign w_bit_idx = {r_k, 2'b00};
    assign w_a_nib   = r_a[w_bit_idx +: 4];
    assign w_b_nib   = r_b[w_bit_idx +: 4] ^ {4{r_p}};
    assign w_sum     = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_c};

    // Grant is gated by RST so both READY outputs read 0 while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RST) begin
                    w_gnt0 = REQ0_VALID && (!REQ1_VALID || !r_ptr);
                    w_gnt1 = REQ1_VALID && (!REQ0_VALID || r_ptr);
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (RES_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= 1'b0;
            r_k   <= '0;
            r_c   <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= 1'b0;
            r_id  <= 1'b0;
            r_s   <= '0;
            r_co  <= 1'b0;
`ifdef ADDSEQ_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a  <= w_gnt1 ? REQ1_A : REQ0_A;
                        r_b  <= w_gnt1 ? REQ1_B : REQ0_B;
                        r_p  <= w_gnt1 ? REQ1_P : REQ0_P;
                        r_c  <= w_gnt1 ? REQ1_P : REQ0_P;
                        r_id <= w_gnt1;
                        r_k  <= '0;
                    end
                end
                ST_RUN: begin
                    r_s[w_bit_idx +: 4] <= w_sum[3:0];
                    r_c                 <= w_sum[4];
                    if (w_last) begin
                        r_co  <= w_sum[4];
`ifdef ADDSEQ_OVF_EN
                        // carry into the top bit, recovered from the sum bit, XOR carry out
                        r_ovf <= (w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3]) ^ w_sum[4];
`endif
                        r_k   <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (RES_READY) begin
                        r_ptr <= ~r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign REQ0_READY = w_gnt0;
    assign REQ1_READY = w_gnt1;
    assign RES_VALID  = (r_state == ST_DONE);
    assign BUSY       = (r_state != ST_IDLE);
    assign RES_S      = r_s;
    assign RES_CO     = r_co;
    assign RES_ID     = r_id;
`ifdef ADDSEQ_OVF_EN
    assign RES_OVF    = r_ovf;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl (NIB=4): vector table, hand-written corner sequences, randomized ops vs. arithmetic model.
module tb_adder_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_p, req1_p;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_co, res_id, busy;
    logic [W-1:0] res_s;
    logic         res_ovf;

    int n_vec  = 0;
    int n_fail = 0;

    adder_seq_ctrl #(.NIB(NIB)) dut (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_A(req0_a), .REQ0_B(req0_b), .REQ0_P(req0_p),
        .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_A(req1_a), .REQ1_B(req1_b), .REQ1_P(req1_p),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_S(res_s), .RES_CO(res_co),
`ifdef ADDSEQ_OVF_EN
        .RES_OVF(res_ovf),
`endif
        .RES_ID(res_id), .BUSY(busy)
    );
`ifndef ADDSEQ_OVF_EN
    assign res_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        p;
        logic [15:0] exp_s;
        logic        exp_co;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on whole operands.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic p);
        logic [15:0] s;
        logic        co;
        int          sr;
        if (!p) begin
            {co, s} = {1'b0, a} + {1'b0, b};
            sr = int'($signed(a)) + int'($signed(b));
        end else begin
            s  = a - b;
            co = (a >= b);
            sr = int'($signed(a)) - int'($signed(b));
        end
        return {(sr > 32767 || sr < -32768), co, s};
    endfunction

    task automatic set_req(input int id, input logic v, input logic [15:0] a, input logic [15:0] b, input logic p);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_p = p;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_p = p;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic p, input int hold,
                          output logic [15:0] s, output logic co, output logic ovf, output logic rid, output int lat);
        int   n;
        logic rdy;
        set_req(id, 1'b1, a, b, p);
        n = 0;
        #1 rdy = (id == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            #1 rdy = (id == 0) ? req0_ready : req1_ready;
            n++;
        end
        if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(id, 1'b0, ~a, ~b, ~p);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        s = res_s; co = res_co; rid = res_id; ovf = res_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_s", 32'(res_s), 32'(s));
            chk("hold_id", 32'(res_id), 32'(rid));
            chk("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_drop", 32'(res_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
    endtask

    vec_t        vt[7];
    logic [15:0] s;
    logic        co, ovf, rid;
    int          lat;
    logic [17:0] m;

    initial begin
        vt[0] = '{0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vt[1] = '{1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[2] = '{1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        vt[3] = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[4] = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[5] = '{1, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 16'h1111; req0_b = 16'h2222; req0_p = 1'b0;
        req1_a = 16'h3333; req1_b = 16'h4444; req1_p = 1'b1;
        #12;
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_outs", {13'd0, res_valid, res_co, res_id, res_s}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(res_ovf), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();

        foreach (vt[i]) begin
            run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].p, 0, s, co, ovf, rid, lat);
            chk($sformatf("vec%0d_s", i), 32'(s), 32'(vt[i].exp_s));
            chk($sformatf("vec%0d_co", i), 32'(co), 32'(vt[i].exp_co));
            chk($sformatf("vec%0d_id", i), 32'(rid), 32'(vt[i].id));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(NIB));
`ifdef ADDSEQ_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].exp_ovf));
`endif
        end

        run_op(1, 16'hABCD, 16'h1111, 1'b0, 5, s, co, ovf, rid, lat);
        chk("hold5_s", 32'(s), 32'h0000BCDE);
        chk("hold5_id", 32'(rid), 32'd1);

        // Round-robin with both requesters permanently valid.
        begin
            int ids[4];
            int cyc[4];
            int got, bad, c;
            do_reset();
            set_req(0, 1'b1, 16'h0101, 16'h0202, 1'b0);
            set_req(1, 1'b1, 16'h0303, 16'h0404, 1'b1);
            res_ready = 1'b1;
            got = 0; bad = 0; c = 0;
            while (got < 4 && c < 80) begin
                #1;
                if (busy && (req0_ready || req1_ready)) bad++;
                if (req0_ready || req1_ready) begin
                    ids[got] = req1_ready ? 1 : 0;
                    cyc[got] = c;
                    got++;
                end
                @(negedge clk);
                c++;
            end
            chk("rr_count", 32'(got), 32'd4);
            chk("rr_busy_grant", 32'(bad), 32'd0);
            for (int i = 0; i < got; i++) chk($sformatf("rr_id%0d", i), 32'(ids[i]), 32'(i % 2));
            for (int i = 1; i < got; i++) chk($sformatf("rr_gap%0d", i), 32'(cyc[i] - cyc[i-1]), 32'(NIB + 2));
            set_req(0, 1'b0, 0, 0, 1'b0);
            set_req(1, 1'b0, 0, 0, 1'b0);
            repeat (8) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end

        // Reset pulsed while nibble 2 is being computed.
        begin
            int hi;
            do_reset();
            set_req(0, 1'b1, 16'h1111, 16'h1111, 1'b0);
            #1 chk("mid_accept", 32'(req0_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk("mid_partial", 32'(res_s[7:0]), 32'h22);
            rst = 1'b1;
            #1;
            chk("mid_rst_outs", {13'd0, res_valid, res_co, res_id, res_s}, 32'd0);
            chk("mid_rst_busy", 32'(busy), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            hi = 0;
            repeat (10) begin
                @(negedge clk);
                if (res_valid || busy) hi++;
            end
            chk("mid_no_result", 32'(hi), 32'd0);
            run_op(0, 16'h0001, 16'h0001, 1'b0, 0, s, co, ovf, rid, lat);
            chk("post_rst_s", 32'(s), 32'h2);
            chk("post_rst_id", 32'(rid), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            int          id;
            logic [15:0] a, b;
            logic        p;
            id = int'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            p  = 1'($urandom_range(0, 1));
            if (i % 8 == 0) b = a;
            m = model(a, b, p);
            run_op(id, a, b, p, int'($urandom_range(0, 2)), s, co, ovf, rid, lat);
            chk($sformatf("rnd%0d_s", i), 32'(s), 32'(m[15:0]));
            chk($sformatf("rnd%0d_co", i), 32'(co), 32'(m[16]));
            chk($sformatf("rnd%0d_id", i), 32'(rid), 32'(id));
`ifdef ADDSEQ_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(m[17]));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
